// File: rtl/tag_mem_master_pkg.sv
// Shared types and constants for the on-chip memory copy master.
// The FSM state enum, the default bus geometry and the modulo-DEPTH
// address increment used by both address pointers.
package tag_mem_master_pkg;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 12288;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Next word address: the last word (depth-1) wraps to 0. Anything at or
    // beyond the last word also returns to 0 so no carry reaches unused bits.
    function automatic logic [31:0] wrap_inc(input logic [31:0] v, input logic [31:0] depth);
        if (v >= depth - 32'd1) begin
            return 32'd0;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/tag_nios_system_mem_copy_master_if.sv
// Avalon-MM port towards the on-chip memory's second slave port.
//
// Protocol: there is no valid/ready pair and no waitrequest. A cycle with
// avm_chipselect=1 is always accepted by the memory. avm_write=1 marks a write
// of avm_writedata (with avm_byteenable) to avm_address; avm_write=0 marks a
// read whose avm_readdata is valid exactly one cycle later and at no other time.
interface tag_nios_system_mem_copy_master_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   avm_address;
    logic                avm_chipselect;
    logic                avm_write;
    logic [DATA_W/8-1:0] avm_byteenable;
    logic [DATA_W-1:0]   avm_writedata;
    logic [DATA_W-1:0]   avm_readdata;
    logic                avm_clken;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write,
        output avm_byteenable,
        output avm_writedata,
        output avm_clken,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write,
        input  avm_byteenable,
        input  avm_writedata,
        input  avm_clken,
        output avm_readdata
    );
endinterface

// File: rtl/mem_addr_wrap_ctr.sv
// Word-address pointer with synchronous load and modulo-DEPTH increment.
// ptr_d is the value the pointer takes at the next edge, so registered bus
// outputs can be computed one cycle ahead from it.
module mem_addr_wrap_ctr
    import tag_mem_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] load_val,
    output logic [ADDR_W-1:0] ptr_d
);

    logic [ADDR_W-1:0] ptr_q;

    // Next pointer: load wins over increment; otherwise hold.
    always_comb begin
        ptr_d = ptr_q;
        if (load) begin
            ptr_d = load_val;
        end else if (inc) begin
            ptr_d = ADDR_W'(wrap_inc(32'(ptr_q), 32'(DEPTH)));
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/tag_nios_system_mem_copy_master.sv
// Avalon-MM block copy master for the system on-chip memory.
// Each word is copied as RD (address), CAP (capture read data), WR (write).
// Optional feature macro: MEM_COPY_FILL_EN adds a fill mode that writes a
// constant word to consecutive destinations, one word per cycle.
// All outputs are registered; they are computed from the next state.
module tag_nios_system_mem_copy_master
    import tag_mem_master_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W-1:0] length,
`ifdef MEM_COPY_FILL_EN
    input  logic              fill_mode,
    input  logic [DATA_W-1:0] fill_data,
`endif
    output logic              busy,
    output logic              done,
    output state_t            dbg_state,
    tag_nios_system_mem_copy_master_if.master avm
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   remaining_q, remaining_d;
    logic                fill_q, fill_d;
    logic                ptr_load, ptr_inc;
    logic [ADDR_W-1:0]   src_ptr_d, dst_ptr_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cs_q, cs_d;
    logic                write_q, write_d;
    logic                clken_q, clken_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W/8-1:0] be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                start_fill;
    logic [DATA_W-1:0]   start_fill_data;

`ifdef MEM_COPY_FILL_EN
    assign start_fill      = fill_mode;
    assign start_fill_data = fill_data;
`else
    assign start_fill      = 1'b0;
    assign start_fill_data = '0;
`endif

    mem_addr_wrap_ctr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_src_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ptr_load),
        .inc      (ptr_inc),
        .load_val (src_addr),
        .ptr_d    (src_ptr_d)
    );

    mem_addr_wrap_ctr #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dst_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ptr_load),
        .inc      (ptr_inc),
        .load_val (dst_addr),
        .ptr_d    (dst_ptr_d)
    );

    // Next-state, job registers and data register; start only counts in IDLE.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        fill_d      = fill_q;
        wdata_d     = wdata_q;
        ptr_load    = 1'b0;
        ptr_inc     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    ptr_load    = 1'b1;
                    remaining_d = length;
                    fill_d      = start_fill;
                    if (start_fill) begin
                        wdata_d = start_fill_data;
                    end
                    if (length == '0) begin
                        state_d = ST_DONE;
                    end else if (start_fill) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                state_d = ST_CAP;
            end
            ST_CAP: begin
                // Read data from the RD cycle is valid now.
                wdata_d = avm.avm_readdata;
                state_d = ST_WR;
            end
            ST_WR: begin
                ptr_inc     = 1'b1;
                remaining_d = remaining_q - ADDR_W'(1);
                if (remaining_q == ADDR_W'(1)) begin
                    state_d = ST_DONE;
                end else if (fill_q) begin
                    state_d = ST_WR;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered output values decoded from the state entered at the next edge.
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        cs_d    = 1'b0;
        write_d = 1'b0;
        addr_d  = '0;
        be_d    = '0;
        clken_d = 1'b1;
        case (state_d)
            ST_RD: begin
                busy_d = 1'b1;
                cs_d   = 1'b1;
                addr_d = src_ptr_d;
            end
            ST_CAP: begin
                busy_d = 1'b1;
            end
            ST_WR: begin
                busy_d  = 1'b1;
                cs_d    = 1'b1;
                write_d = 1'b1;
                addr_d  = dst_ptr_d;
                be_d    = '1;
            end
            ST_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State, job and output registers; reset abandons any job at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            fill_q      <= 1'b0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cs_q        <= 1'b0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            clken_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            fill_q      <= fill_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cs_q        <= cs_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            clken_q     <= clken_d;
        end
    end

    assign busy               = busy_q;
    assign done               = done_q;
    assign dbg_state          = state_q;
    assign avm.avm_address    = addr_q;
    assign avm.avm_chipselect = cs_q;
    assign avm.avm_write      = write_q;
    assign avm.avm_byteenable = be_q;
    assign avm.avm_writedata  = wdata_q;
    assign avm.avm_clken      = clken_q;

endmodule
